// File: rtl/wb_bram_slave.sv
// Wishbone B4 classic slave bridging single-word accesses onto a registered-read BRAM port.
// Define WB_BRAM_ADDR_CHECK_EN to error-terminate misaligned or out-of-window requests.
module wb_bram_slave #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 14,
  parameter int WB_ADDR_WIDTH = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0]    wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0]  wb_sel_i,
  output logic [DATA_WIDTH-1:0]    wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic [ADDR_WIDTH-1:0]    bram_addr,
  output logic [DATA_WIDTH/8-1:0]  bram_w_en,
  output logic [DATA_WIDTH-1:0]    bram_wdata,
  input  logic [DATA_WIDTH-1:0]    bram_rdata
);

`ifdef WB_BRAM_ADDR_CHECK_EN
  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;
`endif

  state_t state;
  logic   req;
  logic   legal;

  assign req = wb_cyc_i & wb_stb_i;

`ifdef WB_BRAM_ADDR_CHECK_EN
  assign legal = (wb_adr_i[1:0] == 2'b00) &&
    (wb_adr_i[WB_ADDR_WIDTH-1:ADDR_WIDTH+2] ==
     BASE_ADDR[WB_ADDR_WIDTH-1:ADDR_WIDTH+2]);
  assign wb_err_o = (state == ERR) & wb_cyc_i;
`else
  // Without checking, the window aliases across the whole bus.
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[WB_ADDR_WIDTH-1:ADDR_WIDTH+2],
                        wb_adr_i[1:0]};
  assign legal    = 1'b1;
  assign wb_err_o = 1'b0;
`endif

  assign bram_addr  = wb_adr_i[ADDR_WIDTH+1:2];
  assign bram_wdata = wb_dat_i;
  assign wb_ack_o   = (state == ACK) & wb_cyc_i;

  // The write commits on the same edge that moves IDLE -> ACK.
  assign bram_w_en = (!rst && state == IDLE && req && wb_we_i && legal)
                     ? wb_sel_i : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wb_dat_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            if (!legal) begin
`ifdef WB_BRAM_ADDR_CHECK_EN
              state <= ERR;
`else
              state <= IDLE;
`endif
            end else if (wb_we_i) begin
              state <= ACK;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else begin
            wb_dat_o <= bram_rdata;
            state    <= ACK;
          end
        end
        ACK: state <= IDLE;
`ifdef WB_BRAM_ADDR_CHECK_EN
        ERR: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
